// File: rtl/store_narrow_serializer.sv
// store_narrow_serializer
//
// Store-side narrowing/serialising stage between the EX/MEM store request and a
// byte-wide data memory. A request is truncated to byte, halfword or word width,
// checked for alignment and then written one byte per cycle, big-endian (most
// significant byte of the narrowed value at the lowest address).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  store request present
//   req_ready_o  request can be accepted (idle only)
//   req_addr_i   byte address of the store
//   req_data_i   store data; low 8/16/32 bits used
//   req_size_i   00 byte, 01 halfword, 10 word, 11 illegal
//   mem_we_o     byte write valid
//   mem_ready_i  memory accepts the current byte
//   mem_addr_o   byte address of the current write
//   mem_data_o   byte being written
//   busy_o       high while sending
//   done_o       one-cycle pulse after the last byte is accepted
//   misalign_o   one-cycle pulse when a request is rejected
module store_narrow_serializer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_data_i,
  input  logic [1:0]        req_size_i,
  output logic              mem_we_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              misalign_o
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  // Narrowed value left-aligned so the next byte to send is always [31:24].
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  // Index of the final byte (N-1).
  logic [1:0]        last_q, last_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;
  logic              illegal;
  logic              sending;

  always_comb begin
    illegal = 1'b0;
    case (req_size_i)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = req_addr_i[0];
      2'b10:   illegal = (req_addr_i[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    last_d     = last_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (illegal) begin
            misalign_d = 1'b1;
          end else begin
            state_d = StSend;
            base_d  = req_addr_i;
            idx_d   = 2'd0;
            case (req_size_i)
              2'b00: begin
                shift_d = {req_data_i[7:0], 24'h0};
                last_d  = 2'd0;
              end
              2'b01: begin
                shift_d = {req_data_i[15:0], 16'h0};
                last_d  = 2'd1;
              end
              default: begin
                shift_d = req_data_i;
                last_d  = 2'd3;
              end
            endcase
          end
        end
      end
      StSend: begin
        if (mem_ready_i) begin
          idx_d   = idx_q + 2'd1;
          shift_d = {shift_q[23:0], 8'h00};
          if (idx_q == last_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      base_q     <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  assign sending     = (state_q == StSend);
  assign req_ready_o = (state_q == StIdle);
  assign mem_we_o    = sending;
  assign busy_o      = sending;
  // Gated to zero in idle so the port rests at its reset value.
  assign mem_addr_o  = sending ? (base_q + ADDR_W'(idx_q)) : '0;
  assign mem_data_o  = sending ? shift_q[31:24] : 8'h00;
  assign done_o      = done_q;
  assign misalign_o  = misalign_q;

endmodule
